serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller: accepts two WIDTH-bit operands + carry-in over a
//  valid/ready handshake, sequences one shared sheffer-gate full adder (9 NAND
//  instances) LSB-first, one bit per clock, and returns sum + carry-out over a
//  valid/ready handshake. Area-minimal alternative to the parallel ripple adder.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range 1..64
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      controller can accept operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout valid (DONE only)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//  cout       out  1      carry-out of bit WIDTH-1
//  busy       out  1      1 in RUN or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0,
//   sum=0, cout=0, shift regs, carry reg, bit counter all 0. Takes effect
//   immediately, mid-RUN/DONE included; in-flight result discarded, never output.
//  Full adder: only sheffer instances. n1=!(x&y) n2=!(x&n1) n3=!(y&n1)
//   p=!(n2&n3) n5=!(p&c) n6=!(p&n5) n7=!(c&n5) s=!(n6&n7) co=!(n1&n5);
//   x,y = LSBs of A/B shift regs, c = carry reg.
//  FSM:
//   IDLE: in_ready=1. in_valid&in_ready at edge -> load A<=a, B<=b, carry<=cin,
//     cnt<=0, -> RUN. Otherwise stay.
//   RUN: in_ready=0. Each edge: sum shift reg <= {s, sum[WIDTH-1:1]},
//     A,B >>=1, carry<=co, cnt<=cnt+1. On edge where cnt==WIDTH-1: cout<=co,
//     -> DONE. in_valid ignored (not latched).
//   DONE: out_valid=1, sum/cout stable. out_valid&out_ready at edge -> IDLE.
//     out_valid stays high until accepted (no drop under backpressure).
//  Latency: accept at edge k -> out_valid high after edge k+WIDTH; throughput
//   one op per WIDTH+2 cycles min (accept, WIDTH RUN edges, handshake-out).
//  in_ready is 0 in DONE even if out_ready=1; new op accepted earliest the
//   cycle after the output handshake.
//  out_ready while out_valid=0: ignored. cnt width = max(1,$clog2(WIDTH)).
//  WIDTH=1: RUN lasts exactly one edge, then DONE.
//  sum/cout hold last result in IDLE until next DONE overwrites (sum register is
//   the shift reg; only valid when out_valid=1).
//  Carry chain: cout = bit WIDTH of a+b+cin; no overflow flag.
// TESTING
//  W=8: a=8'h5A b=8'h3C cin=0 -> after 8 RUN edges out_valid=1, sum=8'h96, cout=0
//  W=8: a=8'hFF b=8'h01 cin=0 -> sum=8'h00 cout=1; a=8'hFF b=8'hFF cin=1 ->
//   sum=8'hFF cout=1
//  Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout stable,
//   in_ready=0; out_ready=1 -> one handshake, IDLE next cycle, in_ready=1
//  in_valid held with a=8'h11 b=8'h22 during RUN of 8'h01+8'h01 -> result
//   8'h02; 8'h11+8'h22 accepted only once back in IDLE -> 8'h33
//  rst_n=0 asynchronously at RUN cnt=3 -> same-instant in_ready=1, out_valid=0,
//   busy=0; after release 8'h0F+8'h01 -> 8'h10 cout=0 (no stale carry)
//  W=1 instance: a=1 b=1 cin=1 -> one RUN edge, sum=1 cout=1; random 1000 ops
//   W=8 vs a+b+cin reference model -> zero mismatches

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared NAND-only full adder walks the
// operands LSB-first, one bit per clock, behind valid/ready handshakes.

// Two-input NAND, the only gate used in the shared full adder.
module sheffer (
  input  logic x_i,
  input  logic y_i,
  output logic z_o
);
  assign z_o = ~(x_i & y_i);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q, busy_q;

  // Shared full adder: x/y are the operand LSBs, c is the running carry.
  logic n1, n2, n3, p, n5, n6, n7, s, co;
  sheffer u_n1 (.x_i(a_q[0]), .y_i(b_q[0]),  .z_o(n1));
  sheffer u_n2 (.x_i(a_q[0]), .y_i(n1),      .z_o(n2));
  sheffer u_n3 (.x_i(b_q[0]), .y_i(n1),      .z_o(n3));
  sheffer u_p  (.x_i(n2),     .y_i(n3),      .z_o(p));
  sheffer u_n5 (.x_i(p),      .y_i(carry_q), .z_o(n5));
  sheffer u_n6 (.x_i(p),      .y_i(n5),      .z_o(n6));
  sheffer u_n7 (.x_i(carry_q),.y_i(n5),      .z_o(n7));
  sheffer u_s  (.x_i(n6),     .y_i(n7),      .z_o(s));
  sheffer u_co (.x_i(n1),     .y_i(n5),      .z_o(co));

  // Sum shifts right with the new bit entering at the MSB (works for WIDTH=1).
  always_comb begin
    sum_d = sum_q >> 1;
    sum_d[WIDTH-1] = s;
  end

  // Controller FSM; handshake/status outputs are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= co;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q      <= co;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Result held until consumed; new input only once back in IDLE.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule
